// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding,
// default widths and the opcode field position.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } seq_state_e;

  localparam int          PC_W_DEF        = 6;
  localparam int          CNT_W_DEF       = 16;
  localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  function automatic logic is_halt(input logic [31:0] w, input logic [5:0] op);
    return w[OPC_HI:OPC_LO] == op;
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Four-phase instruction sequencer: owns the PC, gates register-file writes
// to WRITEBACK, latches ALU flags and provides run / step / halt control.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         PC_W        = PC_W_DEF,
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int         CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [31:0]      instr,
  input  logic             dec_regwrite,
  input  logic             alu_equal,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic [PC_W-1:0]  pc_out,
  output logic [31:0]      ir,
  output logic             rf_we,
  output logic [2:0]       flags,
  output logic             step_ack,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [31:0]      r_ir;
  logic [2:0]       r_flags;
  logic [CNT_W-1:0] r_retired;
  logic             r_step_mode;
  logic             r_step_ack;
  logic             r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_flags     <= '0;
      r_retired   <= '0;
      r_step_mode <= 1'b0;
      r_step_ack  <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_step_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // run_en takes priority over a coincident step request
          if (run_en) begin
            r_step_mode <= 1'b0;
            r_state     <= S_FETCH;
          end else if (step_req) begin
            r_step_mode <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH:   r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= instr;
          if (is_halt(instr, HALT_OPCODE)) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state  <= S_EXECUTE;
          end
        end
        S_EXECUTE: r_state <= S_WRITEBACK;
        S_WRITEBACK: begin
          r_flags   <= {alu_overflow, alu_carry, alu_equal};
          r_pc      <= r_pc + PC_W'(1);
          r_retired <= (&r_retired) ? r_retired : r_retired + CNT_W'(1);
          if (r_step_mode) begin
            r_step_ack <= 1'b1;
            r_state    <= S_IDLE;
          end else if (halt_req || !run_en) begin
            r_state    <= S_IDLE;
          end else begin
            r_state    <= S_FETCH;
          end
        end
        S_HALTED:  r_state <= S_HALTED;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded from the live state so an async reset in WRITEBACK drops it at once
  assign rf_we    = (r_state == S_WRITEBACK) && dec_regwrite;
  assign pc_out   = r_pc;
  assign ir       = r_ir;
  assign flags    = r_flags;
  assign step_ack = r_step_ack;
  assign halted   = r_halted;
  assign state    = r_state;
  assign retired  = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a 1-cycle-latency instruction memory.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_en = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic [31:0] instr;
  logic        dec_regwrite = 1'b1;
  logic        alu_equal = 1'b0, alu_carry = 1'b0, alu_overflow = 1'b0;
  logic [5:0]  pc_out;
  logic [31:0] ir;
  logic        rf_we;
  logic [2:0]  flags;
  logic        step_ack, halted;
  logic [2:0]  state;
  logic [15:0] retired;

  logic [31:0] imem [64];
  int n_checks = 0;
  int n_fail   = 0;
  int we_seen;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req), .halt_req(halt_req),
    .instr(instr), .dec_regwrite(dec_regwrite), .alu_equal(alu_equal),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .pc_out(pc_out), .ir(ir),
    .rf_we(rf_we), .flags(flags), .step_ack(step_ack), .halted(halted),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) instr <= imem[pc_out];

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_1000 + i;

    // reset held with run_en high
    run_en = 1'b1;
    tick(2);
    check("rst_pc", pc_out, 0);
    check("rst_state", state, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_retired", retired, 0);
    check("rst_ir", ir, 0);
    check("rst_flags", flags, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;

    // free run: rf_we in cycle 4 then every 4 cycles
    alu_equal = 1'b1;
    tick(3);
    check("run_c3_we", rf_we, 0);
    check("run_c3_state", state, 3);
    tick();
    check("run_c4_we", rf_we, 1);
    check("run_c4_pc", pc_out, 0);
    tick();
    check("run_c5_we", rf_we, 0);
    check("run_c5_flags", flags, 3'b001);
    tick(3);
    check("run_c8_we", rf_we, 1);
    check("run_c8_pc", pc_out, 1);
    check("run_c8_ir", ir, 32'h0000_1001);

    // halt_req during EXECUTE of instruction 2
    tick(3);
    check("hreq_exec", state, 3);
    halt_req = 1'b1;
    tick();
    check("hreq_wb_we", rf_we, 1);
    check("hreq_wb_pc", pc_out, 2);
    tick();
    halt_req = 1'b0;
    run_en   = 1'b0;
    check("hreq_idle", state, 0);
    check("hreq_pc", pc_out, 3);
    check("hreq_ret", retired, 3);
    tick(2);
    check("hreq_stay", state, 0);

    // single step, second request during EXECUTE ignored
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_fetch", state, 1);
    tick(2);
    check("step_exec", state, 3);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_wb_we", rf_we, 1);
    check("step_wb_ack", step_ack, 0);
    tick();
    check("step_ack", step_ack, 1);
    check("step_pc", pc_out, 4);
    check("step_ret", retired, 4);
    check("step_idle", state, 0);
    check("step_idle_we", rf_we, 0);
    tick();
    check("step_ack_drop", step_ack, 0);
    check("step_no_queue", state, 0);

    // async reset mid-WRITEBACK
    run_en = 1'b1;
    tick(4);
    check("arst_wb_we", rf_we, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", rf_we, 0);
    check("arst_state", state, 0);
    check("arst_pc", pc_out, 0);
    check("arst_ret", retired, 0);
    check("arst_flags", flags, 0);
    tick();
    rst = 1'b0;

    // wrap from pc 63 and flag latch timing
    tick(252);
    check("wrap_wb62_pc", pc_out, 62);
    check("wrap_wb62_flags", flags, 3'b001);
    tick(4);
    check("wrap_wb63_pc", pc_out, 63);
    check("wrap_wb63_state", state, 4);
    alu_overflow = 1'b1; alu_carry = 1'b1; alu_equal = 1'b0;
    run_en = 1'b0;
    check("wrap_wb63_flags", flags, 3'b001);
    tick();
    check("wrap_pc", pc_out, 0);
    check("wrap_flags", flags, 3'b110);
    check("wrap_ret", retired, 64);
    check("wrap_idle", state, 0);

    // halt opcode at address 3
    rst = 1'b1;
    tick();
    imem[3] = 32'hFC00_0000;
    rst = 1'b0;
    run_en = 1'b1;
    tick(15);
    check("hop_state", state, 5);
    check("hop_halted", halted, 1);
    check("hop_pc", pc_out, 3);
    check("hop_ret", retired, 3);
    check("hop_ir", ir, 32'hFC00_0000);
    we_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step_req = (i % 5 == 0);
      halt_req = (i == 7);
      if (rf_we) we_seen++;
      tick();
    end
    step_req = 1'b0;
    halt_req = 1'b0;
    check("hop_no_we", we_seen, 0);
    check("hop_stay", state, 5);
    check("hop_pc_hold", pc_out, 3);
    rst = 1'b1;
    #1;
    check("hop_rst_halted", halted, 0);
    check("hop_rst_state", state, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencer that owns the program counter and paces the existing fetch/decode/ALU/register-file datapath. Each instruction runs through FETCH, DECODE, EXECUTE and WRITEBACK. The block gates register-file writes to a single cycle, latches ALU flags, and supports free-run, single-step and halt control for bring-up and debug. It sits between the clocked instruction memory and the controller/register file, replacing the free-running PC + adder pair.

## Interface
- PC_W, 6, program-counter width (instruction-memory word address)
- HALT_OPCODE, 6'h3F, value of instr[31:26] that stops execution
- CNT_W, 16, retired-instruction counter width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- run_en  in  1  level; free-run while high
- step_req  in  1  single-cycle pulse; execute exactly one instruction from IDLE
- halt_req  in  1  level; stop at next instruction boundary
- instr  in  32  instruction-memory read data (valid one cycle after pc_out)
- dec_regwrite  in  1  controller's RegWrite decode of ir
- alu_equal, alu_carry, alu_overflow  in  1 each  ALU flags
- pc_out  out  PC_W  instruction-memory address / current PC
- ir  out  32  latched instruction register, feeds controller
- rf_we  out  1  register-file write enable
- flags  out  3  {overflow, carry, equal} latched at WRITEBACK
- step_ack  out  1  one-cycle pulse when a stepped instruction retires
- halted  out  1  high in HALTED state
- state  out  3  current FSM state, debug
- retired  out  CNT_W  retired-instruction count

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5.
- IDLE: if run_en, go to FETCH with step_mode=0. Else if step_req, go to FETCH with step_mode=1. Else stay.
- FETCH: pc_out is stable and memory read is in flight. Go to DECODE.
- DECODE: ir <= instr. If instr[31:26]==HALT_OPCODE, go to HALTED; ir is loaded, PC is not advanced, and the count does not change. Otherwise go to EXECUTE.
- EXECUTE: operands and ALU settle. No state updates. Go to WRITEBACK.
- WRITEBACK:
  - rf_we = dec_regwrite (combinational, this state only).
  - flags <= ALU flags.
  - pc <= pc+1, wrapping modulo 2^PC_W.
  - retired <= retired+1, saturating at all-ones.
  - If step_mode, pulse step_ack and go to IDLE.
  - Else if halt_req or !run_en, go to IDLE.
  - Else go to FETCH.
- HALTED: terminal. Leaves only on rst. run_en, step_req and halt_req are ignored.
- Ignored inputs:
  - step_req outside IDLE is ignored; it is not queued.
  - step_req while run_en is high in IDLE is ignored (run wins).
  - halt_req is sampled only at WRITEBACK and never aborts an instruction mid-flight.
- rf_we is 0 in every state other than WRITEBACK.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, pc_out=0, ir=0, flags=0, retired=0.
  - rf_we=0, step_ack=0, halted=0, step_mode=0.
- Reset mid-instruction abandons it with no register write. If rst is asserted during WRITEBACK, rf_we drops combinationally with the state.
- Free-run throughput: 4 cycles per instruction. From IDLE, the first rf_we occurs in cycle 4 after run_en is sampled high.
- Instruction memory has 1-cycle read latency. pc_out is held constant from FETCH through WRITEBACK, and instr is sampled only at the DECODE clock edge.
- The register-file write commits on the rising edge that ends WRITEBACK. The PC increment and flag latch occur on the same edge.
- step_ack is high in the cycle that follows the stepped WRITEBACK, which is the first IDLE cycle.
- PC wrap: pc_out=2^PC_W-1 retires to 0 with no special action.

## Structure
- Shared package cpu_pkg holds:
  - the state enum (3-bit encoding above)
  - HALT_OPCODE and PC_W defaults
  - opcode field slice constants (31:26)
- No sub-module is required.
- A small `sat_counter` for `retired` is acceptable if the codebase already has one.

## Test plan
- Reset: hold rst with run_en=1 and memory holding non-halt instructions. Expect pc_out=0, state=0, rf_we=0, retired=0. After release, expect rf_we on cycle 4, then every 4 cycles, with pc_out going 0,1,2.
- Single step: run_en=0, pulse step_req once. Expect exactly one rf_we pulse, step_ack one cycle later, pc_out=1, retired=1, state=IDLE. A second step_req given during EXECUTE is ignored.
- Halt opcode at address 3 (instr=32'hFC000000): expect 3 retirements, then HALTED with halted=1 and pc_out=3. Expect no further rf_we even with run_en=1 and step_req pulses, until rst.
- halt_req: assert during EXECUTE of instruction 2. Expect that instruction to complete (rf_we high, retired=3), then IDLE with pc_out=3.
- Async reset during WRITEBACK with dec_regwrite=1: rf_we falls before the next edge, no register write occurs, and all outputs return to reset values.
- Wrap and flags: PC_W=6 from pc 63. Expect retirement to set pc_out=0. The ALU flags {1,1,0} presented at WRITEBACK appear on flags=3'b110 the following cycle.
